aes_vector_sequencer: RTL and testbench

AES_VECTOR_SEQUENCER -- requirements
Module: aes_vector_sequencer

---
 rtl/aes_vector_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_aes_vector_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_vector_sequencer.sv
// Known-answer self-test sequencer: runs FIPS-197 encrypt/decrypt vectors for each enabled key length.
// Optional response timeout: define AES_SEQ_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module aes_vector_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   mode_mask,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [127:0] req_data,
  output logic [255:0] req_key,
  output logic [1:0]   req_klen,
  output logic         req_dir,
  input  logic         rsp_valid,
  output logic         rsp_ready,
  input  logic [127:0] rsp_data,
  output logic         busy,
  output logic         done,
  output logic [2:0]   pass,
  output logic [2:0]   fail
);

  localparam logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FULL_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef enum logic [2:0] {
    IDLE, SEND_ENC, WAIT_ENC, SEND_DEC, WAIT_DEC, NEXT, DONE
  } state_t;

  state_t     state;
  logic [2:0] mask;
  logic [1:0] mode;
  logic [2:0] start_sel;
  logic [2:0] next_sel;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Shorter keys are MSB-aligned with the unused tail forced to zero.
  function automatic logic [255:0] key_for(input logic [1:0] m);
    case (m)
      2'd0:    key_for = {FULL_KEY[255:128], 128'h0};
      2'd1:    key_for = {FULL_KEY[255:64], 64'h0};
      default: key_for = FULL_KEY;
    endcase
  endfunction

  function automatic logic [127:0] expected_ct(input logic [1:0] m);
    case (m)
      2'd0:    expected_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      2'd1:    expected_ct = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: expected_ct = 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  // Returns {found, mode} for the lowest set bit of m.
  function automatic logic [2:0] lowest_mode(input logic [2:0] m);
    if (m[0])      lowest_mode = 3'b1_00;
    else if (m[1]) lowest_mode = 3'b1_01;
    else if (m[2]) lowest_mode = 3'b1_10;
    else           lowest_mode = 3'b0_00;
  endfunction

  function automatic logic [2:0] modes_above(input logic [1:0] m);
    case (m)
      2'd0:    modes_above = 3'b110;
      2'd1:    modes_above = 3'b100;
      default: modes_above = 3'b000;
    endcase
  endfunction

  always_comb begin
    start_sel = lowest_mode(mode_mask);
    next_sel  = lowest_mode(mask & modes_above(mode));
  end

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
  logic          timed_out;
  assign timed_out = (wait_cnt == TMO_LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask      <= 3'b000;
      mode      <= 2'd0;
      req_valid <= 1'b0;
      req_data  <= '0;
      req_key   <= '0;
      req_klen  <= 2'd0;
      req_dir   <= 1'b0;
      rsp_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 3'b000;
      fail      <= 3'b000;
`ifdef AES_SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mask <= mode_mask;
            pass <= 3'b000;
            fail <= 3'b000;
            if (start_sel[2]) begin
              busy      <= 1'b1;
              done      <= 1'b0;
              mode      <= start_sel[1:0];
              req_valid <= 1'b1;
              req_dir   <= 1'b0;
              req_data  <= PLAINTEXT;
              req_key   <= key_for(start_sel[1:0]);
              req_klen  <= start_sel[1:0];
              state     <= SEND_ENC;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        SEND_ENC, SEND_DEC: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            rsp_ready <= 1'b1;
            state     <= (state == SEND_ENC) ? WAIT_ENC : WAIT_DEC;
`ifdef AES_SEQ_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end

        // A matching ciphertext is fed straight back as the decrypt request.
        WAIT_ENC: begin
          if (rsp_valid) begin
            rsp_ready <= 1'b0;
            if (rsp_data == expected_ct(mode)) begin
              req_valid <= 1'b1;
              req_dir   <= 1'b1;
              req_data  <= rsp_data;
              state     <= SEND_DEC;
            end else begin
              fail[mode] <= 1'b1;
              state      <= NEXT;
            end
          end
`ifdef AES_SEQ_TIMEOUT_EN
          else if (timed_out) begin
            rsp_ready  <= 1'b0;
            fail[mode] <= 1'b1;
            state      <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        WAIT_DEC: begin
          if (rsp_valid) begin
            rsp_ready <= 1'b0;
            if (rsp_data == PLAINTEXT) pass[mode] <= 1'b1;
            else                       fail[mode] <= 1'b1;
            state <= NEXT;
          end
`ifdef AES_SEQ_TIMEOUT_EN
          else if (timed_out) begin
            rsp_ready  <= 1'b0;
            fail[mode] <= 1'b1;
            state      <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        NEXT: begin
          if (next_sel[2]) begin
            mode      <= next_sel[1:0];
            req_valid <= 1'b1;
            req_dir   <= 1'b0;
            req_data  <= PLAINTEXT;
            req_key   <= key_for(next_sel[1:0]);
            req_klen  <= next_sel[1:0];
            state     <= SEND_ENC;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Bench for aes_vector_sequencer: FIPS-197 table-driven core model plus request/result scoreboards.
module tb_aes_vector_sequencer;

  localparam int           TMO = 16;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FULL_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] MASK128 = {{128{1'b1}}, {128{1'b0}}};
  localparam logic [255:0] MASK192 = {{192{1'b1}}, {64{1'b0}}};

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         start     = 1'b0;
  logic [2:0]   mode_mask = 3'b000;
  logic         req_valid;
  logic         req_ready = 1'b0;
  logic [127:0] req_data;
  logic [255:0] req_key;
  logic [1:0]   req_klen;
  logic         req_dir;
  logic         rsp_valid = 1'b0;
  logic         rsp_ready;
  logic [127:0] rsp_data  = '0;
  logic         busy;
  logic         done;
  logic [2:0]   pass;
  logic [2:0]   fail;

  aes_vector_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_mask(mode_mask),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_key(req_key), .req_klen(req_klen), .req_dir(req_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   klen;
    logic         dir;
    logic [127:0] data;
    logic [255:0] key;
  } req_t;

  req_t       exp_req_q[$];
  logic [5:0] exp_res_q[$];
  int total = 0;
  int bad   = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int last_xfer_cyc = 0;
  int stall_budget = 0;
  int stall_seen = 0;
  bit watch_stall = 1'b0;
  bit corrupt_mode1 = 1'b0;
  bit drop_mode0 = 1'b0;

  function automatic logic [255:0] key_of(input logic [1:0] k);
    case (k)
      2'd0:    return FULL_KEY & MASK128;
      2'd1:    return FULL_KEY & MASK192;
      default: return FULL_KEY;
    endcase
  endfunction

  function automatic logic [127:0] ct_of(input logic [1:0] k);
    case (k)
      2'd0:    return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      2'd1:    return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      2'd2:    return 128'h8ea2b7ca516745bfeafc49904b496089;
      default: return 128'h0;
    endcase
  endfunction

  function automatic req_t mk_req(input logic [1:0] k, input logic d, input logic [127:0] data);
    req_t r;
    r.klen = k;
    r.dir  = d;
    r.data = data;
    r.key  = key_of(k);
    return r;
  endfunction

  // Table-lookup AES core: known vectors map to their FIPS-197 answers, anything else to garbage.
  function automatic logic [127:0] respond(input logic [1:0] k, input logic d,
                                           input logic [127:0] data, input logic [255:0] key,
                                           input bit corrupt);
    logic [127:0] r;
    if (!d) r = (data == PT && key == key_of(k)) ? ct_of(k) : ~data;
    else    r = (data == ct_of(k) && key == key_of(k)) ? PT : ~data;
    if (corrupt && !d && k == 2'd1) r = r ^ 128'h1;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model: 3-cycle response latency, request scoreboard checked on every transfer.
  logic [127:0] rsp_word = '0;
  bit           pend = 1'b0;
  int           lat = 0;
  req_t         want;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      pend = 1'b0;
      rsp_valid <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (pend) begin
        if (lat > 1) lat--;
        else begin
          rsp_valid <= 1'b1;
          rsp_data  <= rsp_word;
          pend = 1'b0;
        end
      end
      if (req_valid && req_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        checkOutput("request_expected", 256'(exp_req_q.size() > 0), 256'(1));
        if (exp_req_q.size() > 0) begin
          want = exp_req_q.pop_front();
          checkOutput("req_klen", 256'(req_klen), 256'(want.klen));
          checkOutput("req_dir", 256'(req_dir), 256'(want.dir));
          checkOutput("req_data", 256'(req_data), 256'(want.data));
          checkOutput("req_key", req_key, want.key);
        end
        if (!(drop_mode0 && req_klen == 2'd0)) begin
          pend = 1'b1;
          lat = 3;
          rsp_word = respond(req_klen, req_dir, req_data, req_key, corrupt_mode1);
        end
      end
      if (req_valid && !req_ready && stall_budget > 0) stall_budget--;
      req_ready <= (stall_budget == 0);
    end
  end

  always @(negedge clk) begin
    if (watch_stall && req_valid && !req_ready) begin
      stall_seen++;
      checkOutput("stall_req_data", 256'(req_data), 256'(PT));
      checkOutput("stall_req_key", req_key, key_of(2'd0));
      checkOutput("stall_req_ctrl", 256'({req_klen, req_dir}), 256'(0));
    end
  end

  task automatic applyStimulus(input logic [2:0] mask, input logic [2:0] enc_ok,
                               input logic [2:0] exp_pass, input logic [2:0] exp_fail);
    for (int m = 0; m < 3; m++) begin
      if (mask[m]) begin
        exp_req_q.push_back(mk_req(2'(m), 1'b0, PT));
        if (enc_ok[m]) exp_req_q.push_back(mk_req(2'(m), 1'b1, ct_of(2'(m))));
      end
    end
    exp_res_q.push_back({exp_pass, exp_fail});
    @(negedge clk);
    mode_mask = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finishRun(input string tag, input int bound);
    logic [5:0] res;
    for (int i = 0; i < bound && done !== 1'b1; i++) @(negedge clk);
    checkOutput({tag, "_done"}, 256'(done), 256'(1));
    checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
    res = exp_res_q.pop_front();
    checkOutput({tag, "_pass_fail"}, 256'({pass, fail}), 256'(res));
    checkOutput({tag, "_requests_left"}, 256'(exp_req_q.size()), 256'(0));
    exp_req_q.delete();
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", 256'({req_valid, rsp_ready, busy, done, pass, fail, req_klen, req_dir}), 256'(0));
    checkOutput("reset_data", 256'(req_data), 256'(0));
    checkOutput("reset_key", req_key, 256'(0));
    reset = 1'b0;

    // Empty mask finishes at once without touching the core.
    applyStimulus(3'b000, 3'b000, 3'b000, 3'b000);
    checkOutput("empty_done_fast", 256'(done), 256'(1));
    @(negedge clk);
    checkOutput("empty_no_valid", 256'({req_valid, busy}), 256'(0));
    checkOutput("empty_no_transfer", 256'(xfer_cnt), 256'(0));
    finishRun("empty", 2);

    // All modes pass; a second start mid-run must be ignored.
    base = xfer_cnt;
    applyStimulus(3'b111, 3'b111, 3'b111, 3'b000);
    repeat (4) @(negedge clk);
    checkOutput("busy_mid_run", 256'(busy), 256'(1));
    mode_mask = 3'b001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finishRun("all_modes", 300);
    checkOutput("all_modes_transfers", 256'(xfer_cnt - base), 256'(6));

    // Corrupted mode-1 ciphertext: no decrypt for mode 1.
    corrupt_mode1 = 1'b1;
    applyStimulus(3'b111, 3'b101, 3'b101, 3'b010);
    finishRun("corrupt_mode1", 300);
    corrupt_mode1 = 1'b0;

    // Back-pressure: request fields held while req_ready is low.
    stall_seen = 0;
    stall_budget = 5;
    watch_stall = 1'b1;
    applyStimulus(3'b001, 3'b001, 3'b001, 3'b000);
    finishRun("stall", 200);
    watch_stall = 1'b0;
    checkOutput("stall_cycles", 256'(stall_seen), 256'(5));

    // Reset while waiting on the mode-2 decrypt response.
    base = xfer_cnt;
    applyStimulus(3'b111, 3'b111, 3'b111, 3'b000);
    for (int i = 0; i < 300 && xfer_cnt != base + 6; i++) @(negedge clk);
    checkOutput("abort_reached_dec2", 256'(xfer_cnt - base), 256'(6));
    checkOutput("abort_in_wait_dec", 256'({rsp_ready, req_klen, req_dir}), 256'({1'b1, 2'd2, 1'b1}));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ctrl", 256'({req_valid, rsp_ready, busy, done, pass, fail, req_klen, req_dir}), 256'(0));
    checkOutput("abort_data", 256'(req_data), 256'(0));
    checkOutput("abort_key", req_key, 256'(0));
    reset = 1'b0;
    exp_res_q.delete();
    repeat (10) @(negedge clk);
    checkOutput("abort_no_handshake", 256'({xfer_cnt - base, 1'(rsp_ready), 1'(req_valid)}), 256'({32'd6, 2'b00}));
    applyStimulus(3'b111, 3'b111, 3'b111, 3'b000);
    finishRun("after_abort", 300);

`ifdef AES_SEQ_TIMEOUT_EN
    // Mode 0 never answers: it fails exactly TMO cycles after its request transfer.
    drop_mode0 = 1'b1;
    applyStimulus(3'b011, 3'b010, 3'b010, 3'b001);
    for (int i = 0; i < 100 && fail[0] !== 1'b1; i++) @(negedge clk);
    checkOutput("timeout_fail0", 256'(fail[0]), 256'(1));
    checkOutput("timeout_latency", 256'(cyc - last_xfer_cyc), 256'(TMO));
    finishRun("timeout", 300);
    drop_mode0 = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
